instr_fetch_buffer: RTL

Requesting side of the instruction-memory fetch interface. Drives single-cycle `next_instr` pulses into the sequential instruction memory, captures each `instr`/`instr_valid` response, tags it with its PC and buffers it in a small FIFO. The decode stage drains the FIFO through a valid/ready handshake. A credit rule guarantees a response never arrives without FIFO space, so no response is ever dropped.

---
 rtl/instr_fetch_buffer_pkg.sv | 13 +
 rtl/instr_fetch_buffer_if.sv | 25 ++
 rtl/instr_fetch_buffer_fifo.sv | 69 ++++++
 rtl/instr_fetch_buffer.sv | 97 +++++++++
 4 files changed

// File: rtl/instr_fetch_buffer_pkg.sv
// Shared types and default sizes for the instruction fetch buffer.
// Each buffered entry pairs a fetched word with the PC it was fetched from.
package fetch_pkg;

  localparam int FETCH_DEPTH = 4;
  localparam int IMEM_WORDS  = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_buffer_if.sv
// Decode-side valid/ready handshake carrying the buffered word and its PC.
// The fetch buffer drives it as master; the decode stage consumes it as slave.
interface instr_fetch_buffer_if;
  import fetch_pkg::*;

  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_ready;

  modport master (
    output fetch_valid,
    output fetch_instr,
    output fetch_pc,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid,
    input  fetch_instr,
    input  fetch_pc,
    output fetch_ready
  );

endinterface

// File: rtl/instr_fetch_buffer_fifo.sv
// Pointer-based FIFO holding tagged fetch entries.
// Storage is reset too, so the head reads a known value while the FIFO is empty.
module fetch_fifo #(
  parameter int  DEPTH     = 4,
  parameter type entry_t   = logic [63:0],
  parameter entry_t RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  entry_t          storage_q [DEPTH];
  entry_t          storage_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign count   = count_q;
  assign head    = storage_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    storage_d = storage_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push) begin
      storage_d[wr_ptr_q] = push_data;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) storage_q[i] <= RESET_VAL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      storage_q <= storage_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Requesting side of the instruction fetch path: issues credit-limited requests,
// tags each response with its PC and buffers it for the decode stage.
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int          DEPTH     = FETCH_DEPTH,
  parameter int          MEM_DEPTH = IMEM_WORDS,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        fetch_en,
  output logic                        next_instr,
  input  logic [31:0]                 instr,
  input  logic                        instr_valid,
  instr_fetch_buffer_if.master        fetch,
  output logic                        fetch_done,
  output logic                        protocol_err
);

  localparam int IW = $clog2(MEM_DEPTH + 1);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam fetch_entry_t ENTRY_RESET = '{pc: RESET_PC, instr: 32'h0};

  logic [IW-1:0] issued_q, issued_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   next_pc_q, next_pc_d;
  logic          protocol_err_q, protocol_err_d;
  logic          fetch_done_q, fetch_done_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic [CW:0]   outstanding;
  logic          credit_ok, issue_ok, push, pop;
  fetch_entry_t  push_entry, head_entry;

  // A request is only allowed when its response is guaranteed a FIFO slot.
  assign outstanding = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign credit_ok   = outstanding < (CW + 1)'(DEPTH);
  assign issue_ok    = issued_q < IW'(MEM_DEPTH);
  assign next_instr  = reset_n && fetch_en && issue_ok && credit_ok;

  assign push       = instr_valid && inflight_q && !fifo_full;
  assign pop        = !fifo_empty && fetch.fetch_ready;
  assign push_entry = '{pc: next_pc_q, instr: instr};

  always_comb begin
    issued_d       = issued_q;
    inflight_d     = next_instr;
    next_pc_d      = next_pc_q;
    protocol_err_d = protocol_err_q;
    fetch_done_d   = fetch_done_q;
    if (next_instr) issued_d = issued_q + 1'b1;
    if (push) next_pc_d = next_pc_q + 32'd4;
    if (instr_valid && !inflight_q) protocol_err_d = 1'b1;
    if ((issued_q == IW'(MEM_DEPTH)) && !inflight_q && fifo_empty) fetch_done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issued_q       <= '0;
      inflight_q     <= 1'b0;
      next_pc_q      <= RESET_PC;
      protocol_err_q <= 1'b0;
      fetch_done_q   <= 1'b0;
    end else begin
      issued_q       <= issued_d;
      inflight_q     <= inflight_d;
      next_pc_q      <= next_pc_d;
      protocol_err_q <= protocol_err_d;
      fetch_done_q   <= fetch_done_d;
    end
  end

  fetch_fifo #(
    .DEPTH     (DEPTH),
    .entry_t   (fetch_entry_t),
    .RESET_VAL (ENTRY_RESET)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign fetch.fetch_valid = !fifo_empty;
  assign fetch.fetch_instr = head_entry.instr;
  assign fetch.fetch_pc    = head_entry.pc;
  assign fetch_done        = fetch_done_q;
  assign protocol_err      = protocol_err_q;

endmodule
